// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
package regfile_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = i_last;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = (w_j == IDX_W'(NREQ - 1)) ? '0 : w_j + IDX_W'(1);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/regfile_arb.sv
// Round-robin arbiter sharing one register-file port among NREQ requesters.
// Optional per-requester grant counters are enabled by REGFILE_ARB_STATS_EN.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned NADDR  = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NREQ-1:0]              m_req,
  input  logic [NREQ-1:0][NADDR-1:0]   m_addr,
  input  logic [NREQ-1:0][WORD_W-1:0]  m_wdata,
  input  logic [NREQ-1:0][BE_W-1:0]    m_we,
  output logic [NREQ-1:0]              m_gnt,
  output logic [NREQ-1:0]              m_rvalid,
  output logic [WORD_W-1:0]            m_rdata,
  output logic [NADDR-1:0]             s_addr,
  output logic [WORD_W-1:0]            s_wr_data,
  output logic [BE_W-1:0]              s_we,
  output logic                         s_en,
  input  logic [WORD_W-1:0]            s_rd_data
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][31:0]        grant_cnt
`endif
);

  localparam int unsigned IDX_W = idx_w(NREQ);
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_win;
  logic [CNT_W-1:0]   r_cnt;
  logic [NADDR-1:0]   r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic [BE_W-1:0]    r_we;

  logic [NREQ-1:0]    w_pick_gnt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NREQ-1:0]    w_win_oh;
  logic               w_last_wait;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .i_req  (m_req),
    .i_last (r_last),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(NREQ - 1);
      r_win   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|m_req) begin
            r_addr  <= m_addr[w_pick_idx];
            r_wdata <= m_wdata[w_pick_idx];
            r_we    <= m_we[w_pick_idx];
            r_win   <= w_pick_idx;
            r_last  <= w_pick_idx;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_W'(RD_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_wait) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_cnt counts down the remaining WAIT cycles; 1 marks the data-valid cycle.
  assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_W'(1));
  assign w_win_oh    = NREQ'(1) << r_win;

  assign m_gnt     = (r_state == ISSUE) ? w_win_oh : '0;
  assign m_rvalid  = w_last_wait ? w_win_oh : '0;
  assign m_rdata   = s_rd_data;
  assign s_en      = (r_state == ISSUE);
  assign s_we      = (r_state == ISSUE) ? r_we : '0;
  assign s_addr    = r_addr;
  assign s_wr_data = r_wdata;

  // unused_pick keeps the one-hot picker output referenced for lint.
  logic w_unused_pick;
  assign w_unused_pick = ^w_pick_gnt;

`ifdef REGFILE_ARB_STATS_EN
  logic [NREQ-1:0][31:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_regfile_arb.sv
// Self-checking bench for regfile_arb: directed steps, contention, reset, random traffic.
module tb_regfile_arb;
  import regfile_arb_pkg::*;

`ifdef REGFILE_ARB_STATS_EN
  localparam int unsigned NREQ = 3;
`else
  localparam int unsigned NREQ = 2;
`endif
  localparam int unsigned NADDR  = 6;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                        clk;
  logic                        rstn;
  logic [NREQ-1:0]             m_req;
  logic [NREQ-1:0][NADDR-1:0]  m_addr;
  logic [NREQ-1:0][31:0]       m_wdata;
  logic [NREQ-1:0][3:0]        m_we;
  logic [NREQ-1:0]             m_gnt;
  logic [NREQ-1:0]             m_rvalid;
  logic [31:0]                 m_rdata;
  logic [NADDR-1:0]            s_addr;
  logic [31:0]                 s_wr_data;
  logic [3:0]                  s_we;
  logic                        s_en;
  logic [31:0]                 s_rd_data;
`ifdef REGFILE_ARB_STATS_EN
  logic [NREQ-1:0][31:0]       grant_cnt;
`endif

  int total;
  int bad;
  logic [31:0] ref_mem [DEPTH];

  regfile_arb #(
    .NREQ   (NREQ),
    .NADDR  (NADDR),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_we      (m_we),
    .m_gnt     (m_gnt),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .s_addr    (s_addr),
    .s_wr_data (s_wr_data),
    .s_we      (s_we),
    .s_en      (s_en),
    .s_rd_data (s_rd_data)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = w[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  // Register-file model with one cycle of read latency; contents reload in reset.
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (s_en) begin
      for (int b = 0; b < 4; b++) if (s_we[b]) mem[s_addr][8*b +: 8] <= s_wr_data[8*b +: 8];
      s_rd_data <= mem[s_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " m_gnt"}, 32'(m_gnt), 32'h0);
    chk({tag, " m_rvalid"}, 32'(m_rvalid), 32'h0);
    chk({tag, " s_en"}, 32'(s_en), 32'h0);
    chk({tag, " s_we"}, 32'(s_we), 32'h0);
    chk({tag, " s_addr"}, 32'(s_addr), 32'h0);
    chk({tag, " s_wr_data"}, s_wr_data, 32'h0);
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    m_req = '0;
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    rstn = 1'b1;
  endtask

  // Single uncontended access from requester r, starting in an IDLE cycle.
  task automatic access(input int r, input logic [NADDR-1:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input string tag);
    logic [31:0] exp_rd;
    m_addr[r]  = a;
    m_wdata[r] = wd;
    m_we[r]    = be;
    m_req[r]   = 1'b1;
    tick();
    chk({tag, " gnt"}, 32'(m_gnt), oh(r));
    chk({tag, " s_en"}, 32'(s_en), 32'h1);
    chk({tag, " s_addr"}, 32'(s_addr), 32'(a));
    chk({tag, " s_we"}, 32'(s_we), 32'(be));
    chk({tag, " s_wr_data"}, s_wr_data, wd);
    exp_rd     = ref_mem[a];
    ref_mem[a] = merge(ref_mem[a], wd, be);
    m_req[r]   = 1'b0;
    repeat (RD_LAT) tick();
    chk({tag, " wait s_en"}, 32'(s_en), 32'h0);
    chk({tag, " wait s_we"}, 32'(s_we), 32'h0);
    chk({tag, " rvalid"}, 32'(m_rvalid), oh(r));
    if (be == 4'h0) chk({tag, " rdata"}, m_rdata, exp_rd);
    tick();
    chk({tag, " rvalid clear"}, 32'(m_rvalid), 32'h0);
  endtask

  initial begin
    int g_total;
    int n;
    int ph;
    int cnt [NREQ];
    logic [31:0] exp_g;
    logic [31:0] exp_v;
    int m_last, idle_at, g_cyc, v_cyc, g_own, j;
    bit found, g_rd;
    logic [31:0] g_data;
    logic [NADDR-1:0] g_addr;

    total   = 0;
    bad     = 0;
    m_req   = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = '0;
    rstn    = 1'b1;
    #2;

    // Reset values
    do_reset();
    chk_idle_outputs("reset");
`ifdef REGFILE_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("reset grant_cnt", grant_cnt[i], 32'h0);
`endif

    // Read, write, read-back, byte-enable merge
    access(0, 6'd5, 32'h0, 4'h0, "rd5");
    access(1, 6'd2, 32'h0000_00A5, 4'hF, "wr2");
    access(0, 6'd2, 32'h0, 4'h0, "rd2");
    access(1, 6'd7, 32'h1111_1111, 4'hF, "wr7");
    access(1, 6'd7, 32'h0000_3C00, 4'b0010, "be7");
    access(0, 6'd7, 32'h0, 4'h0, "rd7");

    // Continuous contention from reset: strict rotation, one grant per RD_LAT+2 cycles
    do_reset();
    g_total = 6 * NREQ;
    for (int i = 0; i < NREQ; i++) begin
      m_addr[i] = NADDR'(10 + i);
      m_we[i]   = 4'h0;
      cnt[i]    = 0;
    end
    m_req = '1;
    for (int cyc = 0; cyc < 3 * g_total + 3; cyc++) begin
      n     = (cyc - 1) / (RD_LAT + 2);
      ph    = (cyc - 1) % (RD_LAT + 2);
      exp_g = (cyc >= 1 && ph == 0 && n < g_total) ? oh(n % NREQ) : 32'h0;
      exp_v = (cyc >= 1 && ph == RD_LAT && n < g_total) ? oh(n % NREQ) : 32'h0;
      chk("cont gnt", 32'(m_gnt), exp_g);
      chk("cont rvalid", 32'(m_rvalid), exp_v);
      if (exp_v != 0) chk("cont rdata", m_rdata, ref_mem[10 + n % NREQ]);
      for (int i = 0; i < NREQ; i++) cnt[i] += int'(m_gnt[i]);
`ifdef REGFILE_ARB_STATS_EN
      if (cyc == 2 + 3 * (3 * NREQ - 1)) begin
        for (int i = 0; i < NREQ; i++) chk("stats grant_cnt", grant_cnt[i], 32'd3);
      end
`endif
      if (cyc == 1 + 3 * (g_total - 1)) m_req = '0;
      tick();
    end
    for (int i = 0; i < NREQ; i++) chk("cont count", 32'(cnt[i]), 32'd6);

    // Reset during the data-valid WAIT cycle of a read
    m_addr[0] = 6'd5;
    m_we[0]   = 4'h0;
    m_req[0]  = 1'b1;
    tick();
    chk("rstwait gnt", 32'(m_gnt), oh(0));
    m_req = '0;
    tick();
    #1;
    rstn = 1'b0;
    #1;
    chk_idle_outputs("rstwait");
    tick();
    chk("rstwait held rvalid", 32'(m_rvalid), 32'h0);
    tick();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    rstn  = 1'b1;
    m_req = '1;
    chk("rstwait idle rvalid", 32'(m_rvalid), 32'h0);
    tick();
    chk("rstwait first gnt", 32'(m_gnt), oh(0));
    m_req = '0;
    tick();
    chk("rstwait rvalid", 32'(m_rvalid), oh(0));
    tick();

    // Random traffic against a cycle-level round-robin model
    do_reset();
    m_last  = NREQ - 1;
    idle_at = 0;
    g_cyc   = -1;
    v_cyc   = -1;
    g_own   = 0;
    g_rd    = 1'b0;
    g_data  = '0;
    g_addr  = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_g = (cyc == g_cyc) ? oh(g_own) : 32'h0;
      exp_v = (cyc == v_cyc) ? oh(g_own) : 32'h0;
      chk("rnd gnt", 32'(m_gnt), exp_g);
      chk("rnd rvalid", 32'(m_rvalid), exp_v);
      if (cyc == v_cyc && g_rd) chk("rnd rdata", m_rdata, g_data);
      if (cyc == g_cyc) begin
        chk("rnd s_addr", 32'(s_addr), 32'(g_addr));
        m_req[g_own] = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!(cyc == g_cyc && i == g_own)) begin
          if (m_req[i]) begin
            if ($urandom_range(0, 15) == 0) m_req[i] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            m_req[i]   = 1'b1;
            m_addr[i]  = NADDR'($urandom_range(0, 15));
            m_wdata[i] = $urandom;
            m_we[i]    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          end
        end
      end
      if (cyc >= idle_at && m_req != 0) begin
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && m_req[(m_last + k) % NREQ]) begin
            found = 1'b1;
            j     = (m_last + k) % NREQ;
          end
        end
        g_own   = j;
        m_last  = j;
        g_cyc   = cyc + 1;
        v_cyc   = cyc + 1 + RD_LAT;
        idle_at = cyc + 2 + RD_LAT;
        g_addr  = m_addr[j];
        g_rd    = (m_we[j] == 4'h0);
        g_data  = ref_mem[g_addr];
        ref_mem[g_addr] = merge(ref_mem[g_addr], m_wdata[j], m_we[j]);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
